step_rate_meter: RTL
====================

STEP_RATE_METER -- requirements
Module: step_rate_meter

Interface
REQ-001 The block SHALL have parameter WINDOW, default 4, giving the number of one-second bins summed for the rate; legal values are 1, 2, 3, 4, 5, 6, 10 and 12.
REQ-002 The block SHALL derive a constant SCALE = 60/WINDOW, default 15, used to convert the window sum to pulses per minute.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 sec_tick  input  1  one-cycle strobe, once per second, synchronous to clk.
REQ-006 pulse_in  input  1  asynchronous step pulse; each rising edge is one step.
REQ-007 start  input  1  one-cycle command strobe driving the mode FSM.
REQ-008 ppm  output  10  pulses-per-minute estimate, fed directly to the high-activity tracker.
REQ-009 ppm_valid  output  1  one-cycle strobe marking a ppm update.
REQ-010 total_steps  output  16  accumulated step count.
REQ-011 running  output  1  high only in state RUN.

Function
REQ-012 pulse_in SHALL pass through a two-flop synchronizer, and a step edge SHALL be a 0->1 transition of the synchronized value (edge detect 3 cycles after the input rises).
REQ-013 The FSM SHALL have states IDLE, RUN and PAUSE: IDLE->RUN on start, RUN->PAUSE on start, PAUSE->RUN on start; there is no other transition except reset->IDLE.
REQ-014 On IDLE->RUN the block SHALL clear the window bins, sec_cnt, ppm and total_steps; on PAUSE->RUN it SHALL keep them.
REQ-015 Step edges SHALL be counted only in RUN and ignored in IDLE and PAUSE.
REQ-016 In RUN each step edge SHALL increment 8-bit sec_cnt, saturating at 255, and increment total_steps, saturating at 16'hFFFF.
REQ-017 On sec_tick in RUN the block SHALL shift sec_cnt into the WINDOW-deep bin register (oldest dropped) and clear sec_cnt to 0, or to 1 if a step edge occurs in the same cycle.
REQ-018 A step edge coincident with sec_tick SHALL be counted in total_steps in that cycle and in the new second's sec_cnt.
REQ-019 One cycle after a RUN sec_tick, ppm SHALL equal min(sum of bins x SCALE, 1023) and ppm_valid SHALL pulse high for exactly one cycle.
REQ-020 Arithmetic SHALL use a sum width of at least 12 bits and a product width of at least 16 bits, so saturation applies only at the final clamp to 1023.
REQ-021 During warm-up, empty bins SHALL read 0, so ppm reflects a partial-window sum (no averaging over filled bins only).
REQ-022 sec_tick in IDLE or PAUSE SHALL be ignored: bins shift not, ppm holds, ppm_valid stays 0.
REQ-023 When start and sec_tick coincide, the transition SHALL take effect and the tick SHALL be evaluated against the pre-transition state (RUN->PAUSE: tick processed; PAUSE/IDLE->RUN: tick ignored).
REQ-024 On RUN->PAUSE, sec_cnt SHALL be cleared so a partial second is discarded; ppm and total_steps SHALL hold.
REQ-025 running SHALL be a registered decode of state RUN.

Reset
REQ-026 While reset is low at a clk edge, the block SHALL enter IDLE, drive ppm=0, ppm_valid=0, total_steps=0 and running=0, and clear all bins, sec_cnt and the synchronizer flops.
REQ-027 Reset SHALL take priority over start, sec_tick and pulse_in in the same cycle, including a reset asserted mid-second in RUN.
REQ-028 No output SHALL be X after the first clk edge with reset low.

Verification (WINDOW=4)
REQ-029 Reset test: hold reset low for 3 cycles with pulses and ticks active -> all outputs 0 and running=0 throughout.
REQ-030 Ramp test: start, then 2 edges/second over 4 ticks -> ppm 30, 60, 90, 120, with one ppm_valid per tick; a 5th second with 0 edges -> ppm 90.
REQ-031 Saturation test: 20 edges/second for 4 s -> ppm=1023 (raw 1200); then 300 edges in one second -> that bin is 255.
REQ-032 Boundary test: an edge in the same cycle as sec_tick -> counted in the next bin; total_steps increments once.
REQ-033 Pause test: pause, drive 10 edges and 3 ticks -> ppm, total_steps and bins unchanged and no ppm_valid; resume, 1 tick with 0 edges -> window shifts from the retained contents.
REQ-034 Total saturation test: drive 65540 edges -> total_steps=65535 and holds there.

Source files
------------

// File: rtl/step_rate_meter.sv
// Step-rate meter: counts synchronized step edges per second into a sliding
// window of one-second bins and reports a pulses-per-minute estimate.
module step_rate_meter #(
  parameter int WINDOW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       pulse_in,
  input  logic       start,
  output logic [9:0] ppm,
  output logic       ppm_valid,
  output logic [15:0] total_steps,
  output logic       running
);

  localparam int SCALE = 60 / WINDOW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [7:0]  sec_cnt_q;
  logic [7:0]  bins_q [WINDOW];
  logic [9:0]  ppm_q;
  logic        ppm_valid_q;
  logic [15:0] total_q;
  logic        running_q;

  logic        step_edge;
  logic [11:0] win_sum;
  logic [15:0] win_prod;
  logic [9:0]  ppm_sat;
  logic [7:0]  sec_cnt_inc;
  logic [15:0] total_inc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = PAUSE;
      PAUSE:   if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // The sum is taken over the window as it will look after this tick's shift.
  always_comb begin
    step_edge = sync2_q & ~prev_q;
    win_sum   = 12'(sec_cnt_q);
    for (int i = 0; i < WINDOW - 1; i++) begin
      win_sum = win_sum + 12'(bins_q[i]);
    end
    win_prod    = 16'(win_sum) * 16'(SCALE);
    ppm_sat     = (win_prod > 16'd1023) ? 10'd1023 : win_prod[9:0];
    sec_cnt_inc = (sec_cnt_q == 8'hFF) ? 8'hFF : sec_cnt_q + 8'd1;
    total_inc   = (total_q == 16'hFFFF) ? 16'hFFFF : total_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      sec_cnt_q   <= 8'd0;
      ppm_q       <= 10'd0;
      ppm_valid_q <= 1'b0;
      total_q     <= 16'd0;
      running_q   <= 1'b0;
      for (int i = 0; i < WINDOW; i++) bins_q[i] <= 8'd0;
    end else begin
      sync1_q     <= pulse_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      ppm_valid_q <= 1'b0;
      state_q     <= state_d;
      running_q   <= (state_d == RUN);
      case (state_q)
        IDLE: begin
          if (start) begin
            sec_cnt_q <= 8'd0;
            ppm_q     <= 10'd0;
            total_q   <= 16'd0;
            for (int i = 0; i < WINDOW; i++) bins_q[i] <= 8'd0;
          end
        end
        RUN: begin
          if (step_edge) total_q <= total_inc;
          if (sec_tick) begin
            for (int i = WINDOW - 1; i > 0; i--) bins_q[i] <= bins_q[i-1];
            bins_q[0]   <= sec_cnt_q;
            ppm_q       <= ppm_sat;
            ppm_valid_q <= 1'b1;
            sec_cnt_q   <= step_edge ? 8'd1 : 8'd0;
          end else if (step_edge) begin
            sec_cnt_q <= sec_cnt_inc;
          end
          // Pausing discards the partial second; this overrides the update above.
          if (start) sec_cnt_q <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  assign ppm         = ppm_q;
  assign ppm_valid   = ppm_valid_q;
  assign total_steps = total_q;
  assign running     = running_q;

endmodule
